// File: rtl/dcache_control.sv
// Control FSM for the 4-way, 8-set dcache: drives datapath selects/loads and
// sequences hit, writeback and refill against the cacheline adaptor.

package dimux;
  typedef enum logic {
    mem_wdata256_from_cpu = 1'b0,
    pmem_rdata_from_mem   = 1'b1
  } dimux_sel_t;
endpackage

package domux;
  typedef enum logic [1:0] {
    data_array_0 = 2'd0,
    data_array_1 = 2'd1,
    data_array_2 = 2'd2,
    data_array_3 = 2'd3
  } domux_sel_t;
endpackage

package addrmux;
  typedef enum logic [2:0] {
    mem_address = 3'd0,
    cache_0     = 3'd1,
    cache_1     = 3'd2,
    cache_2     = 3'd3,
    cache_3     = 3'd4
  } addrmux_sel_t;
endpackage

package wemux;
  typedef enum logic [1:0] {
    zeros = 2'd0,
    ones  = 2'd1,
    mbe   = 2'd2
  } wemux_sel_t;
endpackage

module dcache_control #(
  parameter int unsigned CNT_W = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mem_read,
  input  logic                         mem_write,
  output logic                         mem_resp,
  input  logic [3:0]                   hit_o,
  input  logic [3:0]                   valid_o,
  input  logic [3:0]                   dirty_o,
  input  logic [2:0]                   lru_o,
  output dimux::dimux_sel_t            dimux_sel,
  output domux::domux_sel_t            domux_sel,
  output addrmux::addrmux_sel_t        addrmux_sel,
  output wemux::wemux_sel_t [3:0]      wemux_sel,
  output logic [3:0]                   valid_load,
  output logic [3:0]                   dirty_load,
  output logic [3:0]                   tag_load,
  output logic [3:0]                   valid_i,
  output logic [3:0]                   dirty_i,
  output logic                         pmem_read,
  output logic                         pmem_write,
  input  logic                         pmem_resp,
  output logic [CNT_W-1:0]             hit_count,
  output logic [CNT_W-1:0]             miss_count,
  output logic [CNT_W-1:0]             wb_count
);

  typedef enum logic [1:0] {IDLE, CHECK, WRITEBACK, FETCH} state_t;

  state_t     state, state_n;
  logic [1:0] victim, victim_n, victim_c, hit_way;
  logic       refilled, refilled_n;
  logic       hit_inc_c, miss_inc_c, wb_inc_c;

  function automatic addrmux::addrmux_sel_t cache_sel(input logic [1:0] w);
    case (w)
      2'd0:    return addrmux::cache_0;
      2'd1:    return addrmux::cache_1;
      2'd2:    return addrmux::cache_2;
      default: return addrmux::cache_3;
    endcase
  endfunction

  // Hit way from a one-hot vector; multi-hit is illegal upstream
  always_comb begin
    hit_way = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (hit_o[i]) hit_way = 2'(i);
    end
  end

  // Victim: lowest invalid way wins, else tree-PLRU
  always_comb begin
    if (lru_o[0] == 1'b0) victim_c = lru_o[2] ? 2'd2 : 2'd3;
    else                  victim_c = lru_o[1] ? 2'd0 : 2'd1;
    for (int i = 3; i >= 0; i--) begin
      if (!valid_o[i]) victim_c = 2'(i);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      victim   <= 2'd0;
      refilled <= 1'b0;
    end else begin
      state    <= state_n;
      victim   <= victim_n;
      refilled <= refilled_n;
    end
  end

  always_comb begin
    state_n     = state;
    victim_n    = victim;
    refilled_n  = refilled;
    mem_resp    = 1'b0;
    pmem_read   = 1'b0;
    pmem_write  = 1'b0;
    dimux_sel   = dimux::mem_wdata256_from_cpu;
    domux_sel   = domux::data_array_0;
    addrmux_sel = addrmux::mem_address;
    for (int i = 0; i < 4; i++) wemux_sel[i] = wemux::zeros;
    valid_load  = 4'b0000;
    dirty_load  = 4'b0000;
    tag_load    = 4'b0000;
    valid_i     = 4'b0000;
    dirty_i     = 4'b0000;
    hit_inc_c   = 1'b0;
    miss_inc_c  = 1'b0;
    wb_inc_c    = 1'b0;

    unique case (state)
      IDLE: begin
        refilled_n = 1'b0;
        if (mem_read || mem_write) state_n = CHECK;
      end
      CHECK: begin
        if (!(mem_read || mem_write)) begin
          state_n = IDLE;
        end else if (|hit_o) begin
          domux_sel = domux::domux_sel_t'(hit_way);
          mem_resp  = 1'b1;
          hit_inc_c = 1'b1;
          state_n   = IDLE;
          if (mem_write) begin
            wemux_sel[hit_way]  = wemux::mbe;
            dirty_load[hit_way] = 1'b1;
            dirty_i[hit_way]    = 1'b1;
          end
        end else begin
          // The post-refill recheck must not count as a second miss
          victim_n   = victim_c;
          miss_inc_c = !refilled;
          state_n    = (valid_o[victim_c] && dirty_o[victim_c]) ? WRITEBACK : FETCH;
        end
      end
      WRITEBACK: begin
        pmem_write  = 1'b1;
        addrmux_sel = cache_sel(victim);
        domux_sel   = domux::domux_sel_t'(victim);
        if (pmem_resp) begin
          dirty_load[victim] = 1'b1;
          wb_inc_c           = 1'b1;
          state_n            = FETCH;
        end
      end
      FETCH: begin
        pmem_read = 1'b1;
        dimux_sel = dimux::pmem_rdata_from_mem;
        if (pmem_resp) begin
          wemux_sel[victim]  = wemux::ones;
          tag_load[victim]   = 1'b1;
          valid_load[victim] = 1'b1;
          valid_i[victim]    = 1'b1;
          dirty_load[victim] = 1'b1;
          refilled_n         = 1'b1;
          state_n            = CHECK;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Saturating performance counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_count  <= '0;
      miss_count <= '0;
      wb_count   <= '0;
    end else begin
      if (hit_inc_c  && (hit_count  != '1)) hit_count  <= hit_count  + CNT_W'(1);
      if (miss_inc_c && (miss_count != '1)) miss_count <= miss_count + CNT_W'(1);
      if (wb_inc_c   && (wb_count   != '1)) wb_count   <= wb_count   + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_dcache_control.sv
// Directed bench for dcache_control with a small tag/valid/dirty array model
// and a scoreboard of expected counter values per completed request.

module tb_dcache_control;
  localparam int unsigned CW = 4;

  logic clk = 1'b0;
  logic rst;
  logic mem_read, mem_write, mem_resp;
  logic [3:0] hit_o, valid_o, dirty_o;
  logic [2:0] lru_o;
  dimux::dimux_sel_t       dimux_sel;
  domux::domux_sel_t       domux_sel;
  addrmux::addrmux_sel_t   addrmux_sel;
  wemux::wemux_sel_t [3:0] wemux_sel;
  logic [3:0] valid_load, dirty_load, tag_load, valid_i, dirty_i;
  logic pmem_read, pmem_write, pmem_resp;
  logic [CW-1:0] hit_count, miss_count, wb_count;

  always #5 clk = ~clk;

  dcache_control #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
    .hit_o(hit_o), .valid_o(valid_o), .dirty_o(dirty_o), .lru_o(lru_o),
    .dimux_sel(dimux_sel), .domux_sel(domux_sel), .addrmux_sel(addrmux_sel),
    .wemux_sel(wemux_sel),
    .valid_load(valid_load), .dirty_load(dirty_load), .tag_load(tag_load),
    .valid_i(valid_i), .dirty_i(dirty_i),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp),
    .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
  );

  // Datapath array model; preload gives way w the tag w+1
  logic [2:0] cur_set;
  logic [7:0] cur_tag;
  logic       pl_en;
  logic [2:0] pl_set;
  logic [3:0] pl_v, pl_d;
  logic [3:0] mv [8];
  logic [3:0] md [8];
  logic [7:0] mt [8][4];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int s = 0; s < 8; s++) begin
        mv[s] <= 4'b0000;
        md[s] <= 4'b0000;
        for (int w = 0; w < 4; w++) mt[s][w] <= 8'd0;
      end
    end else if (pl_en) begin
      mv[pl_set] <= pl_v;
      md[pl_set] <= pl_d;
      for (int w = 0; w < 4; w++) mt[pl_set][w] <= 8'(w + 1);
    end else begin
      for (int w = 0; w < 4; w++) begin
        if (valid_load[w]) mv[cur_set][w] <= valid_i[w];
        if (dirty_load[w]) md[cur_set][w] <= dirty_i[w];
        if (tag_load[w])   mt[cur_set][w] <= cur_tag;
      end
    end
  end

  always_comb begin
    for (int w = 0; w < 4; w++) hit_o[w] = mv[cur_set][w] && (mt[cur_set][w] == cur_tag);
    valid_o = mv[cur_set];
    dirty_o = md[cur_set];
  end

  typedef struct packed {
    logic [CW-1:0] h;
    logic [CW-1:0] m;
    logic [CW-1:0] w;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_err = 0;
  logic [CW-1:0] e_hit = '0, e_miss = '0, e_wb = '0;
  logic pw_seen = 1'b0;

  function automatic logic [CW-1:0] sat(input logic [CW-1:0] x);
    return (x == '1) ? x : x + CW'(1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
    if (pmem_write) pw_seen = 1'b1;
    chk("pmem_excl", 32'(pmem_read & pmem_write), 32'd0);
    chk("hit_onehot", 32'($onehot0(hit_o)), 32'd1);
  endtask

  task automatic push_exp(input logic h, input logic m, input logic w);
    if (h) e_hit  = sat(e_hit);
    if (m) e_miss = sat(e_miss);
    if (w) e_wb   = sat(e_wb);
    sb.push_back('{h: e_hit, m: e_miss, w: e_wb});
  endtask

  task automatic preload(input logic [2:0] s, input logic [3:0] v, input logic [3:0] d);
    adv();
    pl_en = 1'b1; pl_set = s; pl_v = v; pl_d = d;
    adv();
    pl_en = 1'b0;
  endtask

  // Called at a sample point; waits for mem_resp, then scores counters
  task automatic wait_resp(input int max);
    bit ok;
    exp_t e;
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (mem_resp) begin ok = 1'b1; break; end
      adv(); smp();
    end
    chk("mem_resp_seen", 32'(ok), 32'd1);
    adv();
    mem_read = 1'b0; mem_write = 1'b0;
    smp();
    chk("mem_resp_pulse", 32'(mem_resp), 32'd0);
    if (sb.size() == 0) begin
      chk("sb_nonempty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("hit_count", 32'(hit_count), 32'(e.h));
      chk("miss_count", 32'(miss_count), 32'(e.m));
      chk("wb_count", 32'(wb_count), 32'(e.w));
    end
  endtask

  task automatic hit_req(input logic rd, input logic wr, input logic [2:0] s, input logic [7:0] t);
    push_exp(1'b1, 1'b0, 1'b0);
    adv();
    mem_read = rd; mem_write = wr; cur_set = s; cur_tag = t;
    smp(); adv(); smp();
    wait_resp(1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    wemux::wemux_sel_t [3:0] ew;
    rst = 1'b0; mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
    lru_o = 3'b000; cur_set = 3'd0; cur_tag = 8'd0;
    pl_en = 1'b0; pl_set = 3'd0; pl_v = 4'd0; pl_d = 4'd0;
    for (int i = 0; i < 4; i++) ew[i] = wemux::zeros;

    // Reset state
    adv(); adv(); smp();
    chk("rst_mem_resp", 32'(mem_resp), 32'd0);
    chk("rst_pmem_read", 32'(pmem_read), 32'd0);
    chk("rst_addrmux", 32'(addrmux_sel), 32'(addrmux::mem_address));
    chk("rst_dimux", 32'(dimux_sel), 32'(dimux::mem_wdata256_from_cpu));
    chk("rst_domux", 32'(domux_sel), 32'(domux::data_array_0));
    chk("rst_wemux", 32'(wemux_sel), 32'(ew));
    chk("rst_loads", 32'({valid_load, dirty_load, tag_load, valid_i, dirty_i}), 32'd0);
    chk("rst_hit_count", 32'(hit_count), 32'd0);
    adv(); rst = 1'b1;

    // Reset mid-FETCH abandons the refill asynchronously
    adv(); mem_read = 1'b1; cur_set = 3'd2; cur_tag = 8'd5;
    smp(); adv(); smp();
    chk("abort_check_no_resp", 32'(mem_resp), 32'd0);
    adv(); smp();
    chk("abort_fetch_pread", 32'(pmem_read), 32'd1);
    chk("abort_miss_cnt_pre", 32'(miss_count), 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("abort_pread_async", 32'(pmem_read), 32'd0);
    chk("abort_miss_cnt", 32'(miss_count), 32'd0);
    chk("abort_mem_resp", 32'(mem_resp), 32'd0);
    mem_read = 1'b0;
    adv(); rst = 1'b1;
    smp();
    chk("abort_idle_pread", 32'(pmem_read), 32'd0);
    chk("abort_idle_resp", 32'(mem_resp), 32'd0);

    // Cold read miss, set 2: victim 0, clean refill
    push_exp(1'b1, 1'b1, 1'b0);
    adv(); mem_read = 1'b1; cur_set = 3'd2; cur_tag = 8'd5;
    smp(); adv(); smp();
    chk("cold_check_resp", 32'(mem_resp), 32'd0);
    adv(); smp();
    chk("cold_fetch_pread", 32'(pmem_read), 32'd1);
    chk("cold_fetch_addr", 32'(addrmux_sel), 32'(addrmux::mem_address));
    chk("cold_fetch_dimux", 32'(dimux_sel), 32'(dimux::pmem_rdata_from_mem));
    adv(); pmem_resp = 1'b1;
    smp();
    ew[0] = wemux::ones;
    chk("cold_wemux", 32'(wemux_sel), 32'(ew));
    ew[0] = wemux::zeros;
    chk("cold_tag_load", 32'(tag_load), 32'h1);
    chk("cold_valid_load", 32'(valid_load), 32'h1);
    chk("cold_valid_i", 32'(valid_i), 32'h1);
    chk("cold_dirty", 32'({dirty_load, dirty_i}), 32'h10);
    adv(); pmem_resp = 1'b0;
    smp();
    wait_resp(3);

    // Write hit on way 2 of set 4
    preload(3'd4, 4'b0100, 4'b0000);
    push_exp(1'b1, 1'b0, 1'b0);
    adv(); mem_write = 1'b1; cur_set = 3'd4; cur_tag = 8'd3;
    smp(); adv(); smp();
    ew[2] = wemux::mbe;
    chk("wr_wemux", 32'(wemux_sel), 32'(ew));
    ew[2] = wemux::zeros;
    chk("wr_dirty_load", 32'(dirty_load), 32'h4);
    chk("wr_dirty_i", 32'(dirty_i), 32'h4);
    chk("wr_domux", 32'(domux_sel), 32'(domux::data_array_2));
    chk("wr_mem_resp", 32'(mem_resp), 32'd1);
    wait_resp(1);

    // Dirty miss: set 6 full, PLRU picks way 1 which is dirty
    preload(3'd6, 4'b1111, 4'b0010);
    lru_o = 3'b001;
    push_exp(1'b1, 1'b1, 1'b1);
    adv(); mem_read = 1'b1; cur_set = 3'd6; cur_tag = 8'd9;
    smp(); adv(); smp();
    chk("dm_check_resp", 32'(mem_resp), 32'd0);
    adv(); smp();
    chk("dm_wb_pwrite", 32'(pmem_write), 32'd1);
    chk("dm_wb_addr", 32'(addrmux_sel), 32'(addrmux::cache_1));
    chk("dm_wb_domux", 32'(domux_sel), 32'(domux::data_array_1));
    adv(); smp();
    chk("dm_wb_hold", 32'(pmem_write), 32'd1);
    adv(); pmem_resp = 1'b1;
    smp();
    chk("dm_wb_dirty_load", 32'(dirty_load), 32'h2);
    chk("dm_wb_dirty_i", 32'(dirty_i), 32'h0);
    adv(); pmem_resp = 1'b0;
    smp();
    chk("dm_fetch_pread", 32'(pmem_read), 32'd1);
    chk("dm_fetch_addr", 32'(addrmux_sel), 32'(addrmux::mem_address));
    adv(); pmem_resp = 1'b1;
    smp();
    ew[1] = wemux::ones;
    chk("dm_fetch_wemux", 32'(wemux_sel), 32'(ew));
    ew[1] = wemux::zeros;
    chk("dm_fetch_tag_load", 32'(tag_load), 32'h2);
    adv(); pmem_resp = 1'b0;
    smp();
    wait_resp(3);

    // Clean PLRU miss: set 1 full, lru 000 -> way 3, no writeback
    preload(3'd1, 4'b1111, 4'b0111);
    lru_o = 3'b000;
    pw_seen = 1'b0;
    push_exp(1'b1, 1'b1, 1'b0);
    adv(); mem_read = 1'b1; cur_set = 3'd1; cur_tag = 8'd9;
    smp(); adv(); smp(); adv(); smp();
    chk("cm_fetch_direct", 32'(pmem_read), 32'd1);
    adv(); pmem_resp = 1'b1;
    smp();
    chk("cm_tag_load", 32'(tag_load), 32'h8);
    chk("cm_valid_load", 32'(valid_load), 32'h8);
    adv(); pmem_resp = 1'b0;
    smp();
    wait_resp(3);
    chk("cm_no_pwrite", 32'(pw_seen), 32'd0);

    // Dropped request: back to IDLE, nothing counted
    adv(); mem_read = 1'b1; cur_set = 3'd3; cur_tag = 8'd1;
    smp(); adv(); mem_read = 1'b0;
    smp();
    chk("drop_resp", 32'(mem_resp), 32'd0);
    chk("drop_pread", 32'(pmem_read), 32'd0);
    adv(); smp();
    chk("drop_hit_count", 32'(hit_count), 32'(e_hit));
    chk("drop_miss_count", 32'(miss_count), 32'(e_miss));

    // Both requests high: write wins
    push_exp(1'b1, 1'b0, 1'b0);
    adv(); mem_read = 1'b1; mem_write = 1'b1; cur_set = 3'd4; cur_tag = 8'd3;
    smp(); adv(); smp();
    chk("prio_dirty_load", 32'(dirty_load), 32'h4);
    chk("prio_wemux2", 32'(wemux_sel[2]), 32'(wemux::mbe));
    wait_resp(1);

    // Read hits past saturation of the 4-bit hit counter
    for (int i = 0; i < 12; i++) hit_req(1'b1, 1'b0, 3'd2, 8'd5);
    chk("sat_hit_count", 32'(hit_count), 32'hF);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
